// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style control FSM: Moore state decode drives datapath selects/enables.
// Memory states optionally stall on mem_ready_i; op is latched only via state transitions.
module mc_controller #(
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_J     = 1'b1,
  parameter bit EN_BNE   = 1'b0,
  parameter bit MEM_WAIT = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] op_i6,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       iord_o,
  output logic       enable_wmem_o,
  output logic       ir_write_o,
  output logic       reg_dst_rtrd_o,
  output logic       mem_to_reg_o,
  output logic       enable_wreg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o2,
  output logic [1:0] alu_alt_ctrl_o2,
  output logic [1:0] pc_src_o2,
  output logic       pc_en_o,
  output logic       illegal_o,
  output logic [3:0] state_o4
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e state_q, state_d;
  // Remembers BEQ vs BNE so BRANCH never has to look at op_i6 again.
  logic   bne_q, bne_d;
  logic   rdy;

  assign rdy      = MEM_WAIT ? mem_ready_i : 1'b1;
  assign state_o4 = state_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bne_q   <= bne_d;
    end
  end

  always_comb begin
    state_d         = S_FETCH;
    bne_d           = bne_q;
    iord_o          = 1'b0;
    enable_wmem_o   = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_rtrd_o  = 1'b0;
    mem_to_reg_o    = 1'b0;
    enable_wreg_o   = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o2    = 2'b00;
    alu_alt_ctrl_o2 = 2'b00;
    pc_src_o2       = 2'b00;
    pc_en_o         = 1'b0;
    illegal_o       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b_o2 = 2'b01;
        ir_write_o   = rdy;
        pc_en_o      = rdy;
        state_d      = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_o2 = 2'b11;
        bne_d        = 1'b0;
        case (op_i6)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE: begin
            if (EN_BNE) begin
              state_d = S_BRANCH;
              bne_d   = 1'b1;
            end else begin
              illegal_o = 1'b1;
            end
          end
          OP_ADDI: begin
            if (EN_ADDI) state_d = S_ADDIEX;
            else         illegal_o = 1'b1;
          end
          OP_J: begin
            if (EN_J) state_d = S_JUMP;
            else      illegal_o = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
        state_d      = (op_i6 == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_o  = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg_o  = 1'b1;
        enable_wreg_o = 1'b1;
      end
      S_MEMWR: begin
        iord_o        = 1'b1;
        enable_wmem_o = 1'b1;
        state_d       = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a_o     = 1'b1;
        alu_alt_ctrl_o2 = 2'b10;
        state_d         = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst_rtrd_o = 1'b1;
        enable_wreg_o  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_alt_ctrl_o2 = 2'b01;
        pc_src_o2       = 2'b01;
        pc_en_o         = bne_q ? ~zero_i : zero_i;
      end
      S_ADDIEX: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        enable_wreg_o = 1'b1;
      end
      S_JUMP: begin
        pc_src_o2 = 2'b10;
        pc_en_o   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: dut 0 uses default parameters, dut 1 has ADDI off, BNE on, MEM_WAIT on.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst  [2];
  logic [5:0] op   [2];
  logic       zero [2];
  logic       rdy  [2];

  logic       iord [2], wmem [2], irw [2], regdst [2], m2r [2], wreg [2], srca [2];
  logic       pcen [2], ill [2];
  logic [1:0] srcb [2], aluop [2], pcsrc [2];
  logic [3:0] st   [2];
  logic [14:0] outv [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_controller #(.EN_ADDI(1'b1), .EN_J(1'b1), .EN_BNE(1'b0), .MEM_WAIT(1'b0)) dut0 (
    .clk_i(clk), .reset_i(rst[0]), .op_i6(op[0]), .zero_i(zero[0]), .mem_ready_i(rdy[0]),
    .iord_o(iord[0]), .enable_wmem_o(wmem[0]), .ir_write_o(irw[0]), .reg_dst_rtrd_o(regdst[0]),
    .mem_to_reg_o(m2r[0]), .enable_wreg_o(wreg[0]), .alu_src_a_o(srca[0]), .alu_src_b_o2(srcb[0]),
    .alu_alt_ctrl_o2(aluop[0]), .pc_src_o2(pcsrc[0]), .pc_en_o(pcen[0]), .illegal_o(ill[0]),
    .state_o4(st[0]));

  mc_controller #(.EN_ADDI(1'b0), .EN_J(1'b1), .EN_BNE(1'b1), .MEM_WAIT(1'b1)) dut1 (
    .clk_i(clk), .reset_i(rst[1]), .op_i6(op[1]), .zero_i(zero[1]), .mem_ready_i(rdy[1]),
    .iord_o(iord[1]), .enable_wmem_o(wmem[1]), .ir_write_o(irw[1]), .reg_dst_rtrd_o(regdst[1]),
    .mem_to_reg_o(m2r[1]), .enable_wreg_o(wreg[1]), .alu_src_a_o(srca[1]), .alu_src_b_o2(srcb[1]),
    .alu_alt_ctrl_o2(aluop[1]), .pc_src_o2(pcsrc[1]), .pc_en_o(pcen[1]), .illegal_o(ill[1]),
    .state_o4(st[1]));

  for (genvar g = 0; g < 2; g++) begin : g_pack
    assign outv[g] = {iord[g], wmem[g], irw[g], regdst[g], m2r[g], wreg[g], srca[g],
                      srcb[g], aluop[g], pcsrc[g], pcen[g], ill[g]};
  end

  // Per-state output table: {iord,wmem,irw,regdst,m2r,wreg,srca,srcb,aluop,pcsrc,pcen,illegal}.
  function automatic logic [14:0] exp_out(int s, bit r, bit z, bit bne, bit illg);
    case (s)
      0:  return {2'b00, r, 4'b0000, 2'b01, 2'b00, 2'b00, r, 1'b0};
      1:  return {7'b0, 2'b11, 2'b00, 2'b00, 1'b0, illg};
      2:  return {6'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
      3:  return {1'b1, 6'b0, 8'b0};
      4:  return {4'b0000, 2'b11, 1'b0, 8'b0};
      5:  return {2'b11, 5'b0, 8'b0};
      6:  return {6'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00};
      7:  return {3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 8'b0};
      8:  return {6'b0, 1'b1, 2'b00, 2'b01, 2'b01, (bne ? ~z : z), 1'b0};
      9:  return {6'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
      10: return {5'b0, 1'b1, 1'b0, 8'b0};
      11: return {7'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
      default: return 15'b0;
    endcase
  endfunction

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      op[d] = 6'b000000; zero[d] = 1'b0; rdy[d] = 1'b0;
      do_reset(d);
      @(negedge clk);
      checks++;
      if (st[d] !== 4'd0) begin
        errors++; $display("FAIL reset_state d%0d: got %0d want 0", d, st[d]);
      end
      checks++;
      if (outv[d] !== exp_out(0, (d == 0), 1'b0, 1'b0, 1'b0)) begin
        errors++; $display("FAIL reset_outputs d%0d: got %h want %h", d, outv[d], exp_out(0, (d == 0), 1'b0, 1'b0, 1'b0));
      end
      rdy[d] = 1'b1;
    end
  endtask

  task automatic test_lw;
    int es [6];
    es = '{0, 1, 2, 3, 4, 0};
    op[0] = 6'b100011; rdy[0] = 1'b1; zero[0] = 1'b0;
    do_reset(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (st[0] !== 4'(es[i])) begin
        errors++; $display("FAIL lw_state step%0d: got %0d want %0d", i, st[0], es[i]);
      end
      checks++;
      if ({wreg[0], m2r[0]} !== ((es[i] == 4) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL lw_wb step%0d: got %b want %b", i, {wreg[0], m2r[0]}, (es[i] == 4) ? 2'b11 : 2'b00);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall;
    op[1] = 6'b101011; rdy[1] = 1'b1; zero[1] = 1'b0;
    do_reset(1);
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) begin
      rdy[1] = (i == 3);
      @(negedge clk);
      checks++;
      if (st[1] !== 4'd5 || wmem[1] !== 1'b1) begin
        errors++; $display("FAIL sw_stall cyc%0d: got state %0d wmem %b want 5 1", i, st[1], wmem[1]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (st[1] !== 4'd0) begin
      errors++; $display("FAIL sw_done: got %0d want 0", st[1]);
    end
  endtask

  task automatic test_branch;
    for (int d = 0; d < 2; d++) begin
      for (int zi = 0; zi < 2; zi++) begin
        op[d] = (d == 0) ? 6'b000100 : 6'b000101; rdy[d] = 1'b1; zero[d] = 1'b0;
        do_reset(d);
        repeat (2) begin @(posedge clk); #1; end
        zero[d] = (zi == 1);
        @(negedge clk);
        checks++;
        if (st[d] !== 4'd8 || pcsrc[d] !== 2'b01 || pcen[d] !== ((d == 0) ? (zi == 1) : (zi == 0))) begin
          errors++; $display("FAIL branch d%0d z%0d: got state %0d pcsrc %b pcen %b", d, zi, st[d], pcsrc[d], pcen[d]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (st[d] !== 4'd0) begin
          errors++; $display("FAIL branch_ret d%0d: got %0d want 0", d, st[d]);
        end
      end
    end
  endtask

  task automatic test_addi_disabled;
    op[1] = 6'b001000; rdy[1] = 1'b1; zero[1] = 1'b0;
    do_reset(1);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (st[1] !== 4'd1 || ill[1] !== 1'b1 || wreg[1] !== 1'b0) begin
      errors++; $display("FAIL addi_off_decode: got state %0d ill %b wreg %b want 1 1 0", st[1], ill[1], wreg[1]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (st[1] !== 4'd0 || ill[1] !== 1'b0 || wreg[1] !== 1'b0) begin
      errors++; $display("FAIL addi_off_fetch: got state %0d ill %b wreg %b want 0 0 0", st[1], ill[1], wreg[1]);
    end
  endtask

  task automatic test_reset_execute;
    op[0] = 6'b000000; rdy[0] = 1'b1; zero[0] = 1'b0;
    do_reset(0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (st[0] !== 4'd6) begin
      errors++; $display("FAIL rst_exec_pre: got %0d want 6", st[0]);
    end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (st[0] !== 4'd0 || wreg[0] !== 1'b0) begin
      errors++; $display("FAIL rst_exec_post: got state %0d wreg %b want 0 0", st[0], wreg[0]);
    end
  endtask

  task automatic test_reset_stall;
    op[1] = 6'b101011; rdy[1] = 1'b1; zero[1] = 1'b0;
    do_reset(1);
    repeat (3) begin @(posedge clk); #1; end
    rdy[1] = 1'b0;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (st[1] !== 4'd0 || wmem[1] !== 1'b0 || pcen[1] !== 1'b0) begin
      errors++; $display("FAIL rst_stall: got state %0d wmem %b pcen %b want 0 0 0", st[1], wmem[1], pcen[1]);
    end
    rdy[1] = 1'b1;
  endtask

  task automatic test_jump;
    int es [4];
    es = '{0, 1, 11, 0};
    op[0] = 6'b000010; rdy[0] = 1'b1; zero[0] = 1'b0;
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (st[0] !== 4'(es[i])) begin
        errors++; $display("FAIL jump_state step%0d: got %0d want %0d", i, st[0], es[i]);
      end
      if (es[i] == 11) begin
        checks++;
        if (pcsrc[0] !== 2'b10 || pcen[0] !== 1'b1) begin
          errors++; $display("FAIL jump_pc: got pcsrc %b pcen %b want 10 1", pcsrc[0], pcen[0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Each instruction expands to its architectural state path; wait states repeat while not ready.
  task automatic test_random(input int d, input int n);
    int path[$];
    logic [5:0] iop;
    bit illg, bne, r, z, reff, waitst;
    int s, stalls;
    rdy[d] = 1'b1;
    do_reset(d);
    for (int t = 0; t < n; t++) begin
      path.delete();
      path.push_back(0);
      path.push_back(1);
      illg = 1'b0;
      bne  = 1'b0;
      case ($urandom_range(0, 7))
        0: begin iop = 6'b100011; path.push_back(2); path.push_back(3); path.push_back(4); end
        1: begin iop = 6'b101011; path.push_back(2); path.push_back(5); end
        2: begin iop = 6'b000000; path.push_back(6); path.push_back(7); end
        3: begin iop = 6'b000100; path.push_back(8); end
        4: begin
          iop = 6'b000101;
          if (d == 1) begin path.push_back(8); bne = 1'b1; end
          else illg = 1'b1;
        end
        5: begin
          iop = 6'b001000;
          if (d == 0) begin path.push_back(9); path.push_back(10); end
          else illg = 1'b1;
        end
        6: begin iop = 6'b000010; path.push_back(11); end
        default: begin iop = {2'b11, 4'($urandom)}; illg = 1'b1; end
      endcase
      for (int i = 0; i < path.size(); i++) begin
        s = path[i];
        waitst = (d == 1) && (s == 0 || s == 3 || s == 5);
        stalls = waitst ? $urandom_range(0, 2) : 0;
        for (int c = 0; c <= stalls; c++) begin
          r = waitst ? (c == stalls) : 1'($urandom);
          z = 1'($urandom);
          reff = (d == 1) ? r : 1'b1;
          rdy[d] = r;
          zero[d] = z;
          op[d] = (s == 1 || s == 2) ? iop : 6'($urandom);
          @(negedge clk);
          checks++;
          if (st[d] !== 4'(s)) begin
            errors++; $display("FAIL rand_state d%0d op%b: got %0d want %0d", d, iop, st[d], s);
          end
          checks++;
          if (outv[d] !== exp_out(s, reff, z, bne, illg && s == 1)) begin
            errors++; $display("FAIL rand_out d%0d state%0d: got %h want %h", d, s, outv[d], exp_out(s, reff, z, bne, illg && s == 1));
          end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; op[d] = 6'b0; zero[d] = 1'b0; rdy[d] = 1'b1;
    end
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch();
    test_addi_disabled();
    test_reset_execute();
    test_reset_stall();
    test_jump();
    test_random(0, 150);
    test_random(1, 150);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL provide parameter EN_ADDI, default 1, meaning ADDI opcode supported.
REQ-002 SHALL provide parameter EN_J, default 1, meaning J opcode supported.
REQ-003 SHALL provide parameter EN_BNE, default 0, meaning BNE opcode supported.
REQ-004 SHALL provide parameter MEM_WAIT, default 0; 1 = memory states stall on mem_ready_i, 0 = mem_ready_i ignored (treated as 1).
REQ-005 SHALL have one clock and a synchronous active-high reset, both listed first:
  clk_i  in  1  clock, all state on rising edge
  reset_i  in  1  synchronous active-high reset
  op_i6  in  6  instruction opcode from instruction register
  zero_i  in  1  ALU zero flag
  mem_ready_i  in  1  memory access completes this cycle
  iord_o  out  1  memory address select (0 PC, 1 ALUOut)
  enable_wmem_o  out  1  memory write enable
  ir_write_o  out  1  instruction register load
  reg_dst_rtrd_o  out  1  register destination select (0 rt, 1 rd)
  mem_to_reg_o  out  1  write-back select (0 ALUOut, 1 data reg)
  enable_wreg_o  out  1  register file write enable
  alu_src_a_o  out  1  ALU A select (0 PC, 1 A reg)
  alu_src_b_o2  out  2  ALU B select (00 B reg, 01 const 4, 10 signimm, 11 signimm<<2)
  alu_alt_ctrl_o2  out  2  ALUOp (00 add, 01 sub, 10 funct-decoded)
  pc_src_o2  out  2  next-PC select (00 ALU result, 01 ALUOut, 10 jump target)
  pc_en_o  out  1  PC load enable
  illegal_o  out  1  one-cycle pulse, unsupported opcode decoded
  state_o4  out  4  current FSM state code

Function
REQ-006 SHALL implement a Moore FSM, codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; codes 12-15 unreachable and SHALL go to FETCH next cycle with all outputs at defaults.
REQ-007 SHALL drive every output 0 except as listed per state (defaults 0); state_o4 SHALL equal current state code.
REQ-008 "rdy" below SHALL mean mem_ready_i when MEM_WAIT=1, constant 1 otherwise.
REQ-009 FETCH: iord 0, alu_src_b 01, ALUOp 00, pc_src 00, ir_write_o = pc_en_o = rdy; stays in FETCH while !rdy, else -> DECODE.
REQ-010 DECODE: alu_src_b 11, ALUOp 00; next by op_i6: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 000101 -> BRANCH if EN_BNE; 001000 -> ADDIEX if EN_ADDI; 000010 -> JUMP if EN_J; any other (incl. disabled) -> FETCH with illegal_o=1 that cycle only.
REQ-011 MEMADR: alu_src_a 1, alu_src_b 10, ALUOp 00; -> MEMRD if op_i6=100011, else MEMWR.
REQ-012 MEMRD: iord 1; stays while !rdy, else -> MEMWB.
REQ-013 MEMWB: reg_dst 0, mem_to_reg 1, enable_wreg 1; -> FETCH.
REQ-014 MEMWR: iord 1, enable_wmem_o 1 held every cycle in state; stays while !rdy, else -> FETCH.
REQ-015 EXECUTE: alu_src_a 1, alu_src_b 00, ALUOp 10; -> ALUWB. ALUWB: reg_dst 1, mem_to_reg 0, enable_wreg 1; -> FETCH.
REQ-016 BRANCH: alu_src_a 1, alu_src_b 00, ALUOp 01, pc_src 01; pc_en_o = zero_i for op 000100, = !zero_i for op 000101 (EN_BNE=1); -> FETCH.
REQ-017 ADDIEX: alu_src_a 1, alu_src_b 10, ALUOp 00; -> ADDIWB. ADDIWB: reg_dst 0, mem_to_reg 0, enable_wreg 1; -> FETCH.
REQ-018 JUMP: pc_src 10, pc_en_o 1; -> FETCH.
REQ-019 Latency with rdy=1: R-type/ADDI/LW-write-back... R-type 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles; each !rdy cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
REQ-020 op_i6 SHALL only be sampled in DECODE and MEMADR; zero_i only in BRANCH; all outputs are combinational from state plus those inputs only.

Reset
REQ-021 reset_i high at a rising edge SHALL force state FETCH, overriding any transition, including mid-instruction and during a memory stall.
REQ-022 While state is FETCH after reset, outputs SHALL follow REQ-009 (pc_en_o/ir_write_o = rdy); no write enable (enable_wmem_o, enable_wreg_o) SHALL assert in the reset cycle's following state unless FETCH rules demand it (they do not).

Verification
REQ-023 Reset, then op_i6=100011, rdy=1 -> states 0,1,2,3,4,0; enable_wreg_o=1 and mem_to_reg_o=1 only in state 4.
REQ-024 MEM_WAIT=1, op 101011, mem_ready_i low 3 cycles in MEMWR -> state 5 held 4 cycles, enable_wmem_o=1 all 4, then state 0.
REQ-025 op 000100, zero_i=1 -> pc_en_o=1, pc_src_o2=01 in state 8; zero_i=0 -> pc_en_o=0; EN_BNE=1 op 000101 gives inverse.
REQ-026 EN_ADDI=0, op 001000 -> DECODE then FETCH, illegal_o one-cycle pulse, no enable_wreg_o.
REQ-027 reset_i asserted in state 6 (EXECUTE) -> next state 0, enable_wreg_o never asserted for that instruction.
REQ-028 op 000010 -> states 0,1,11,0; pc_src_o2=10, pc_en_o=1 in state 11.
